dmem_lsu_ctrl: RTL

//  Load/store sequencer between the MEM pipeline stage and a handshaked data memory.

---
 rtl/dmem_lsu_ctrl_if.sv | 34 +++
 rtl/dmem_lsu_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu_ctrl_if.sv
// Data-memory request/response bus between the LSU and the memory.
// The LSU is the master; the memory (or its model) is the slave.
interface dmem_lsu_ctrl_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wmask,
    output dmem_wdata,
    input  dmem_ready,
    input  dmem_rvalid,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wmask,
    input  dmem_wdata,
    output dmem_ready,
    output dmem_rvalid,
    output dmem_rdata
  );
endinterface

// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the MEM stage and a handshaked data memory.
// One access in flight; stalls the pipeline until completion or timeout.
module dmem_lsu_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_op_valid,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        misalign_err,
  output logic        bus_err,
  dmem_lsu_ctrl_if.master dmem
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;

  logic        aligned;
  logic [3:0]  mask_c;
  logic [31:0] wdata_c;
  logic [31:0] shifted;
  logic [31:0] ext_c;
  logic        tmo;

  // Alignment check, byte mask and lane replication of the incoming op
  always_comb begin
    aligned = 1'b0;
    mask_c  = 4'b0000;
    wdata_c = mem_wdata;
    unique case (mem_size)
      2'b00: begin
        aligned = 1'b1;
        mask_c  = 4'b0001 << mem_addr[1:0];
        wdata_c = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        aligned = ~mem_addr[0];
        mask_c  = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{mem_wdata[15:0]}};
      end
      2'b10: begin
        aligned = (mem_addr[1:0] == 2'b00);
        mask_c  = 4'b1111;
        wdata_c = mem_wdata;
      end
      default: begin
        aligned = 1'b0;
        mask_c  = 4'b0000;
        wdata_c = mem_wdata;
      end
    endcase
  end

  // Lane extraction and sign/zero extension of the returned word
  always_comb begin
    shifted = dmem.dmem_rdata >> {off_q, 3'b000};
    ext_c   = shifted;
    unique case (size_q)
      2'b00:
        ext_c = {{24{~uns_q & shifted[7]}},
                 shifted[7:0]};
      2'b01:
        ext_c = {{16{~uns_q & shifted[15]}},
                 shifted[15:0]};
      default:
        ext_c = shifted;
    endcase
  end

  assign tmo = (cnt == CW'(TIMEOUT - 1));

  assign stall = ~rst &
    ((state == REQ) | (state == WAIT_R) |
     ((state == IDLE) & mem_op_valid & aligned));

  assign misalign_err = ~rst & (state == IDLE) &
    mem_op_valid & ~aligned;

  // Sequencer: accept, request, wait for data, complete
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      off_q         <= 2'b00;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      ld_valid      <= 1'b0;
      bus_err       <= 1'b0;
      ld_data       <= '0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wmask <= 4'b0000;
      dmem.dmem_wdata <= '0;
    end else begin
      ld_valid <= 1'b0;
      bus_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_op_valid && aligned) begin
            off_q           <= mem_addr[1:0];
            size_q          <= mem_size;
            uns_q           <= mem_unsigned;
            cnt             <= '0;
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= mem_we;
            dmem.dmem_addr  <= {mem_addr[31:2], 2'b00};
            dmem.dmem_wmask <= mem_we ? mask_c : 4'b0000;
            dmem.dmem_wdata <= wdata_c;
            state           <= REQ;
          end
        end
        REQ: begin
          cnt <= cnt + CW'(1);
          if (dmem.dmem_ready && dmem.dmem_we) begin
            dmem.dmem_req <= 1'b0;
            ld_valid      <= 1'b1;
            state         <= DONE;
          end else if (tmo) begin
            dmem.dmem_req <= 1'b0;
            ld_valid      <= 1'b1;
            bus_err       <= 1'b1;
            ld_data       <= '0;
            state         <= DONE;
          end else if (dmem.dmem_ready) begin
            dmem.dmem_req <= 1'b0;
            state         <= WAIT_R;
          end
        end
        WAIT_R: begin
          cnt <= cnt + CW'(1);
          if (dmem.dmem_rvalid) begin
            ld_data  <= ext_c;
            ld_valid <= 1'b1;
            state    <= DONE;
          end else if (tmo) begin
            ld_data  <= '0;
            ld_valid <= 1'b1;
            bus_err  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
